// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_dp dual-port byte RAM.
// Contents: access-size enum, init-state enum, WORD_BYTES, lane/alignment helpers.
// No ports (package only).
package ram_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_e;

    // True when the access cannot be served: natural alignment violated or reserved size.
    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        logic r;
        case (sz)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = off[0];
            SZ_WORD: r = |off;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Byte lanes of a word touched by an aligned access at byte offset off.
    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Init sequencer: after reset walks word index 0..WORDS-1 (one per cycle), then parks in RUN.
// Ports: clk/rst_n; wr_idx = word being copied, copy_en = copy this cycle, ready = RUN reached.
// Latency: ready rises WORDS cycles after rst_n release; no backpressure, runs freely.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int WORDS = 32,
    localparam int IW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] wr_idx,
    output logic          copy_en,
    output logic          ready
);

    init_state_e   state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        copy_en = 1'b0;
        ready   = 1'b0;
        case (state_q)
            INIT: begin
                copy_en = 1'b1;
                cnt_d   = cnt_q + IW'(1);
                if (cnt_q == IW'(WORDS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign wr_idx = cnt_q;

endmodule

// File: rtl/ram_dp.sv
// Dual-port byte-addressed RAM: port 1 word read-only, port 2 byte/half/word read-write.
// Ports: clk, rst_n, rst_data (init image), ready; req1/addr1 -> rd1/valid1;
//        req2/we2/size2/addr2/wd2 -> rd2/valid2/err2. Responses registered, one cycle latency.
// No backpressure; requests are ignored until ready. Optional RAM_DP_BOUNDS_CHECK_EN
// makes out-of-range accesses error (port 2) or read zero (port 1) instead of wrapping.
module ram_dp
    import ram_pkg::*;
#(
    parameter int MEM_SIZE = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*MEM_SIZE-1:0] rst_data,
    output logic                  ready,
    input  logic                  req1,
    input  logic [31:0]           addr1,
    output logic [31:0]           rd1,
    output logic                  valid1,
    input  logic                  req2,
    input  logic                  we2,
    input  logic [1:0]            size2,
    input  logic [31:0]           addr2,
    input  logic [31:0]           wd2,
    output logic [31:0]           rd2,
    output logic                  valid2,
    output logic                  err2
);

    localparam int WORDS = MEM_SIZE / WORD_BYTES;
    localparam int AW    = $clog2(MEM_SIZE);
    localparam int IW    = AW - 2;

    logic [31:0]   mem_q [WORDS];

    logic [IW-1:0] init_idx;
    logic          copy_en;
    logic [31:0]   init_word;

    ram_init_seq #(.WORDS(WORDS)) u_init_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_idx  (init_idx),
        .copy_en (copy_en),
        .ready   (ready)
    );

    // Little-endian image: word k is exactly bytes 4k..4k+3 of rst_data.
    assign init_word = rst_data[32*int'(init_idx) +: 32];

    logic [IW-1:0] widx1, widx2;
    logic [1:0]    off2;
    size_e         sz2;
    logic          oob1, oob2;
    logic          bad2;
    logic          acc2, wr2;
    logic [3:0]    be2;
    logic [31:0]   wdat2;
    logic [31:0]   rword2, rdat2;

    assign widx1 = addr1[AW-1:2];
    assign widx2 = addr2[AW-1:2];
    assign off2  = addr2[1:0];
    assign sz2   = size_e'(size2);

`ifdef RAM_DP_BOUNDS_CHECK_EN
    assign oob1 = addr1 >= 32'(MEM_SIZE);
    // Aligned accesses never straddle the top of memory (MEM_SIZE is a multiple of 4),
    // so checking the start address covers every byte touched.
    assign oob2 = addr2 >= 32'(MEM_SIZE);
`else
    assign oob1 = 1'b0;
    assign oob2 = 1'b0;
`endif

    // Upper address bits are don't-care when wrapping; port 1 ignores the byte offset.
    logic unused_addr;
    assign unused_addr = ^{addr1[1:0], addr1[31:AW], addr2[31:AW]};

    assign bad2 = misaligned(sz2, off2) | oob2;
    assign acc2 = req2 & ready;
    assign wr2  = acc2 & we2 & ~bad2;
    assign be2  = lane_mask(sz2, off2);

    // Replicating the low bits puts the data on every lane it could target.
    always_comb begin
        case (sz2)
            SZ_BYTE: wdat2 = {4{wd2[7:0]}};
            SZ_HALF: wdat2 = {2{wd2[15:0]}};
            default: wdat2 = wd2;
        endcase
    end

    assign rword2 = mem_q[widx2];

    always_comb begin
        case (sz2)
            SZ_BYTE: rdat2 = {24'h0, rword2[8*off2 +: 8]};
            SZ_HALF: rdat2 = {16'h0, rword2[16*off2[1] +: 16]};
            default: rdat2 = rword2;
        endcase
    end

    // Storage has no reset; contents are defined only once the init walk completes.
    always_ff @(posedge clk) begin
        if (copy_en) begin
            mem_q[init_idx] <= init_word;
        end else if (wr2) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be2[b]) begin
                    mem_q[widx2][8*b +: 8] <= wdat2[8*b +: 8];
                end
            end
        end
    end

    logic [31:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic        valid1_q, valid1_d, valid2_q, valid2_d, err2_q, err2_d;

    // Reads sample mem_q before the same-edge write lands, giving read-before-write.
    always_comb begin
        valid1_d = req1 & ready;
        rd1_d    = rd1_q;
        if (valid1_d) begin
            rd1_d = oob1 ? 32'h0 : mem_q[widx1];
        end
        valid2_d = acc2;
        err2_d   = acc2 & bad2;
        rd2_d    = rd2_q;
        if (acc2) begin
            rd2_d = (we2 | bad2) ? 32'h0 : rdat2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q    <= '0;
            valid1_q <= 1'b0;
            rd2_q    <= '0;
            valid2_q <= 1'b0;
            err2_q   <= 1'b0;
        end else begin
            rd1_q    <= rd1_d;
            valid1_q <= valid1_d;
            rd2_q    <= rd2_d;
            valid2_q <= valid2_d;
            err2_q   <= err2_d;
        end
    end

    assign rd1    = rd1_q;
    assign valid1 = valid1_q;
    assign rd2    = rd2_q;
    assign valid2 = valid2_q;
    assign err2   = err2_q;

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 128, meaning memory size in bytes (power of two, >= 8).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rst_data  input  8 x MEM_SIZE  byte image loaded after reset.
REQ-005 SHALL have port ready  output  1  high once initialisation is complete.
REQ-006 SHALL have ports req1 (input, 1, port-1 read request), addr1 (input, 32, byte address), rd1 (output, 32, read data) and valid1 (output, 1, rd1 valid).
REQ-007 SHALL have ports req2 (input, 1, port-2 request), we2 (input, 1, write enable), size2 (input, 2, access size), addr2 (input, 32, byte address) and wd2 (input, 32, write data).
REQ-008 SHALL have ports rd2 (output, 32, read data), valid2 (output, 1, response valid) and err2 (output, 1, access error).

Function
REQ-009 SHALL run an init FSM with states INIT and RUN; in INIT it copies rst_data bytes 4k..4k+3 into word k, one word per cycle, k = 0 .. MEM_SIZE/4-1.
REQ-010 SHALL enter RUN on the cycle after word MEM_SIZE/4-1 is written, with ready = 1 from that cycle onward.
REQ-011 SHALL ignore req1/req2 while in INIT: no write, no valid1/valid2.
REQ-012 SHALL store data little-endian: byte at addr in bits [7:0], addr+1 in [15:8], and so on.
REQ-013 Port 1 SHALL be read-only and word-wide: addr1[1:0] ignored; rd1/valid1 registered one cycle after req1.
REQ-014 Port 2 size2 encoding SHALL be 00 byte, 01 half, 10 word, 11 reserved.
REQ-015 Port 2 writes (req2 & we2) SHALL update only the addressed lanes from wd2[7:0], wd2[15:0] or wd2[31:0] at the clock edge.
REQ-016 Port 2 reads SHALL return zero-extended data on rd2 one cycle after req2.
REQ-017 Every port-2 request SHALL produce valid2 = 1 one cycle later; for writes rd2 = 0.
REQ-018 A misaligned port-2 access (half with addr2[0]=1, word with addr2[1:0]!=0, or size2=11) SHALL set err2 = 1 with valid2 and rd2 = 0, and SHALL NOT write.
REQ-019 valid1/valid2/err2 SHALL be single-cycle pulses per request; rd1/rd2 SHALL hold their last value while no request is made.
REQ-020 A port-1 read and a port-2 write to the same word in the same cycle SHALL return the old data on rd1 (read-before-write).
REQ-021 A port-2 read in the cycle after a write to the same address SHALL return the new data.

Reset
REQ-022 While rst_n = 0: state = INIT, word counter = 0, ready = 0, valid1 = valid2 = err2 = 0, rd1 = rd2 = 0; memory contents are don't-care.
REQ-023 Assertion of rst_n mid-init or mid-operation SHALL abort immediately; on deassertion the init FSM SHALL restart from word 0.

Configuration
REQ-024 With RAM_DP_BOUNDS_CHECK_EN defined, a port-2 access touching any byte >= MEM_SIZE SHALL give err2 = 1, rd2 = 0 and no write, and a port-1 address >= MEM_SIZE SHALL return rd1 = 0.
REQ-025 Without RAM_DP_BOUNDS_CHECK_EN, addresses SHALL wrap modulo MEM_SIZE (upper bits ignored) and out-of-range SHALL never set err2.

Structure
REQ-026 Package ram_pkg SHALL hold the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), the init-state enum (INIT, RUN) and the constant WORD_BYTES = 4.
REQ-027 The init FSM and word counter SHALL be a sub-module ram_init_seq, outputting the write index, a copy enable and ready.

Verification
REQ-028 Reset/init: rst_data[0..3] = 10,32,54,76 hex, release rst_n -> ready rises after 32 cycles (MEM_SIZE = 128); word read at 0 -> rd1 = 32'h76543210 one cycle later.
REQ-029 Byte/half write: write byte 8'hAB at 1, then half 16'hCDEF at 2 -> word read at 0 = 32'hCDEFAB10; byte read at 3 -> rd2 = 32'h000000CD.
REQ-030 Misaligned: word write 32'h12345678 at addr 2 -> valid2 = 1, err2 = 1; word at 0 unchanged.
REQ-031 Collision: port-1 read and port-2 word write 32'h12345678 to addr 0 in the same cycle -> rd1 = old value; next port-1 read = 32'h12345678.
REQ-032 Bounds: word read at addr 128 -> err2 = 1 with RAM_DP_BOUNDS_CHECK_EN, otherwise returns word 0 data and err2 = 0.
REQ-033 Mid-init reset: pulse rst_n low at init cycle 10 -> ready stays 0 for 32 full cycles after release; requests during INIT give no valid.
